// File: rtl/addsub_pkg.sv
// Shared types for the add/subtract arbiter: FSM state encoding and op codes.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

endpackage

// File: rtl/addsub_core.sv
// Registered W-bit add/subtract producing a W+1 bit result; clear wins over enable.
module addsub_core
  import addsub_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  input  logic         cin_i,
  output logic [W:0]   sum_o
);

  logic [W:0] sum_q;

  // Subtract wraps modulo 2^(W+1); carry-in only participates in add.
  function automatic logic [W:0] addsub_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sub, input logic cin);
    if (sub == SUB) return {1'b0, a} - {1'b0, b};
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  always_ff @(posedge clk) begin
    if (clr_i)     sum_q <= '0;
    else if (en_i) sum_q <= addsub_f(a_i, b_i, sub_i, cin_i);
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/addsub_arb.sv
// Round-robin arbiter in front of a single shared add/subtract unit, one op in flight.
// Optional sticky-grant lock enabled by defining ADDSUB_ARB_LOCK_EN.
module addsub_arb
  import addsub_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*W-1:0]         req_a,
  input  logic [NREQ*W-1:0]         req_b,
  input  logic [NREQ-1:0]           req_sub,
  input  logic [NREQ-1:0]           req_cin,
`ifdef ADDSUB_ARB_LOCK_EN
  input  logic [NREQ-1:0]           req_lock,
`endif
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [W:0]                rsp_sum,
  output logic                      busy
);

  localparam int IDW = $clog2(NREQ);

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, id_q, rr_idx, gnt_idx;
  logic           rr_any, gnt_any, lock_hit, accept, core_en;
  logic [W-1:0]   a_q, b_q;
  logic           sub_q, cin_q;
  logic [W-1:0]   a_arr [NREQ];
  logic [W-1:0]   b_arr [NREQ];
  int             j;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*W +: W];
    assign b_arr[g] = req_b[g*W +: W];
  end

  // Scan from highest offset down so the lowest offset from the pointer wins.
  always_comb begin
    rr_any = 1'b0;
    rr_idx = '0;
    j      = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req_valid[IDW'(j)]) begin
        rr_any = 1'b1;
        rr_idx = IDW'(j);
      end
    end
  end

`ifdef ADDSUB_ARB_LOCK_EN
  logic lock_q;

  assign lock_hit = lock_q && req_valid[id_q];

  // A locked owner that stops requesting in IDLE gives the lock up.
  always_ff @(posedge clk) begin
    if (reset)                               lock_q <= 1'b0;
    else if (accept)                         lock_q <= req_lock[gnt_idx];
    else if (state_q == IDLE && !lock_hit)   lock_q <= 1'b0;
  end
`else
  assign lock_hit = 1'b0;
`endif

  assign gnt_idx = lock_hit ? id_q : rr_idx;
  assign gnt_any = lock_hit | rr_any;
  assign accept  = |req_ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    busy      = 1'b1;
    rsp_valid = 1'b0;
    core_en   = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (gnt_any && !reset) req_ready[gnt_idx] = 1'b1;
      end
      EXEC:    core_en   = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: busy      = 1'b0;
    endcase
  end

  // Locked re-grants leave the rotation pointer where it was.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      id_q  <= '0;
    end else if (accept) begin
      id_q <= gnt_idx;
      if (!lock_hit) ptr_q <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q   <= a_arr[gnt_idx];
      b_q   <= b_arr[gnt_idx];
      sub_q <= req_sub[gnt_idx];
      cin_q <= req_cin[gnt_idx];
    end
  end

  addsub_core #(.W(W)) u_core (
    .clk   (clk),
    .clr_i (reset),
    .en_i  (core_en),
    .a_i   (a_q),
    .b_i   (b_q),
    .sub_i (sub_q),
    .cin_i (cin_q),
    .sum_o (rsp_sum)
  );

  assign rsp_id = id_q;

endmodule

// File: tb/tb_addsub_arb.sv
// Directed bench for addsub_arb: vector table plus reset, rotation, backpressure and lock sequences.
module tb_addsub_arb;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_sub;
  logic [NREQ-1:0]   req_cin;
`ifdef ADDSUB_ARB_LOCK_EN
  logic [NREQ-1:0]   req_lock;
`endif
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [W:0]        rsp_sum;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         idx;
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic       cin;
    logic [8:0] sum;
  } vec_t;

  vec_t vecs [8];

  addsub_arb #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .req_cin   (req_cin),
`ifdef ADDSUB_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                        input logic sub, input logic cin);
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    req_sub[idx]      = sub;
    req_cin[idx]      = cin;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 8'hFF, 8'h01, 1'b0, 1'b1, 9'h101};
    vecs[1] = '{2, 8'h05, 8'h07, 1'b1, 1'b1, 9'h1FE};
    vecs[2] = '{1, 8'h80, 8'h80, 1'b0, 1'b0, 9'h100};
    vecs[3] = '{3, 8'h00, 8'h01, 1'b1, 1'b0, 9'h1FF};
    vecs[4] = '{3, 8'hFF, 8'hFF, 1'b0, 1'b1, 9'h1FF};
    vecs[5] = '{1, 8'h3C, 8'h0C, 1'b1, 1'b0, 9'h030};
    vecs[6] = '{0, 8'h00, 8'h00, 1'b0, 1'b0, 9'h000};
    vecs[7] = '{2, 8'hFF, 8'h00, 1'b1, 1'b1, 9'h0FF};

    reset     = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    req_cin   = '0;
`ifdef ADDSUB_ARB_LOCK_EN
    req_lock  = '0;
`endif
    rsp_ready = 1'b1;

    // Reset state, with every requester asking
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy",      32'(busy),      32'h0);
    chk("rst_rsp_sum",   32'(rsp_sum),   32'h0);
    chk("rst_rsp_id",    32'(rsp_id),    32'h0);
    reset     = 1'b0;
    req_valid = '0;

    // Single-requester vectors; inputs are scrambled right after acceptance
    for (int v = 0; v < 8; v++) begin
      req_valid = '0;
      set_op(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].sub, vecs[v].cin);
      req_valid[vecs[v].idx] = 1'b1;
      #1;
      chk($sformatf("vec%0d_grant", v), 32'(req_ready), 32'd1 << vecs[v].idx);
      @(negedge clk);
      req_valid = '0;
      req_a     = ~req_a;
      req_b     = ~req_b;
      req_sub   = ~req_sub;
      req_cin   = ~req_cin;
      #1;
      chk($sformatf("vec%0d_exec_busy", v),  32'(busy),      32'h1);
      chk($sformatf("vec%0d_exec_valid", v), 32'(rsp_valid), 32'h0);
      @(negedge clk);
      #1;
      chk($sformatf("vec%0d_rsp_valid", v), 32'(rsp_valid), 32'h1);
      chk($sformatf("vec%0d_rsp_sum", v),   32'(rsp_sum),   32'(vecs[v].sum));
      chk($sformatf("vec%0d_rsp_id", v),    32'(rsp_id),    32'(vecs[v].idx));
      @(negedge clk);
      #1;
      chk($sformatf("vec%0d_idle_busy", v),  32'(busy),      32'h0);
      chk($sformatf("vec%0d_idle_valid", v), 32'(rsp_valid), 32'h0);
    end

    // Reset while in EXEC: req1 accepted with pointer at 3
    req_valid = 4'b0010;
    set_op(1, 8'h11, 8'h22, 1'b0, 1'b0);
    #1;
    chk("rex_grant", 32'(req_ready), 32'h2);
    @(negedge clk);
    reset     = 1'b1;
    req_valid = '0;
    #1;
    chk("rex_exec_busy", 32'(busy), 32'h1);
    @(negedge clk);
    #1;
    chk("rex_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rex_busy",      32'(busy),      32'h0);
    chk("rex_rsp_sum",   32'(rsp_sum),   32'h0);
    reset = 1'b0;

    // Rotation from pointer 0 with all requesters held valid
    for (int i = 0; i < NREQ; i++) set_op(i, 8'(i + 1), 8'h10, 1'b0, 1'b0);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 15; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      begin
        int id;
        id = (cyc / 3) % NREQ;
        case (cyc % 3)
          0: begin
            chk($sformatf("rr%0d_grant", cyc), 32'(req_ready), 32'd1 << id);
            chk($sformatf("rr%0d_rsp_valid", cyc), 32'(rsp_valid), 32'h0);
          end
          1: begin
            chk($sformatf("rr%0d_ready", cyc), 32'(req_ready), 32'h0);
            chk($sformatf("rr%0d_busy", cyc),  32'(busy),      32'h1);
          end
          default: begin
            chk($sformatf("rr%0d_rsp_valid", cyc), 32'(rsp_valid), 32'h1);
            chk($sformatf("rr%0d_rsp_id", cyc),    32'(rsp_id),    32'(id));
            chk($sformatf("rr%0d_rsp_sum", cyc),   32'(rsp_sum),   32'h11 + 32'(id));
          end
        endcase
      end
    end
    req_valid = '0;
    @(negedge clk);

    // Backpressure: hold RESP for five cycles with other requesters waiting
    set_op(3, 8'h10, 8'h20, 1'b0, 1'b0);
    req_valid = 4'b1000;
    rsp_ready = 1'b0;
    #1;
    chk("bp_grant", 32'(req_ready), 32'h8);
    @(negedge clk);
    req_valid = 4'b1111;
    req_a     = ~req_a;
    #1;
    chk("bp_exec_ready", 32'(req_ready), 32'h0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("bp%0d_rsp_valid", c), 32'(rsp_valid), 32'h1);
      chk($sformatf("bp%0d_rsp_sum", c),   32'(rsp_sum),   32'h030);
      chk($sformatf("bp%0d_rsp_id", c),    32'(rsp_id),    32'h3);
      chk($sformatf("bp%0d_ready", c),     32'(req_ready), 32'h0);
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    @(negedge clk);
    #1;
    chk("bp_release_valid", 32'(rsp_valid), 32'h0);
    chk("bp_release_busy",  32'(busy),      32'h0);

`ifdef ADDSUB_ARB_LOCK_EN
    // Lock: req1 keeps the grant while valid, then req2 takes over
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    set_op(1, 8'h01, 8'h01, 1'b0, 1'b0);
    set_op(2, 8'h02, 8'h02, 1'b0, 1'b0);
    req_lock  = 4'b0010;
    req_valid = 4'b0110;
    for (int cyc = 0; cyc < 7; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (cyc == 6) req_valid = 4'b0100;
      #1;
      if (cyc == 0 || cyc == 3) chk($sformatf("lock%0d_grant", cyc), 32'(req_ready), 32'h2);
      if (cyc == 6)             chk("lock6_grant", 32'(req_ready), 32'h4);
    end
    req_valid = '0;
    req_lock  = '0;
    repeat (3) @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/addsub_arb.md
ADDSUB_ARB -- requirements
Module: addsub_arb

Interface
Parameters:
- REQ-001 The block SHALL have parameter NREQ, default 4: number of requesters, 2..8.
- REQ-002 The block SHALL have parameter W, default 8: operand width; result width is W+1.

Ports:
- REQ-003 The block SHALL have port clk, input, 1: rising-edge clock.
- REQ-004 The block SHALL have port reset, input, 1: reset, synchronous, active-high.
- REQ-005 The block SHALL have port req_valid, input, NREQ: per-requester operation request.
- REQ-006 The block SHALL have port req_ready, output, NREQ: one-hot grant; a request is accepted when valid and ready are both high at the same clock edge.
- REQ-007 The block SHALL have port req_a, input, NREQ*W: operand A per requester; requester i occupies slice [i*W +: W].
- REQ-008 The block SHALL have port req_b, input, NREQ*W: operand B per requester, same packing as req_a.
- REQ-009 The block SHALL have port req_sub, input, NREQ: 1 = subtract, 0 = add.
- REQ-010 The block SHALL have port req_cin, input, NREQ: carry-in; used for add only.
- REQ-011 The block SHALL have port rsp_valid, output, 1: result available.
- REQ-012 The block SHALL have port rsp_ready, input, 1: consumer accepts the result.
- REQ-013 The block SHALL have port rsp_id, output, clog2(NREQ): index of the requester that owns the result.
- REQ-014 The block SHALL have port rsp_sum, output, W+1: result.
- REQ-015 The block SHALL have port busy, output, 1: high in every FSM state except IDLE.

Function
- REQ-016 The block SHALL implement a three-state FSM: IDLE, EXEC, RESP.
  - IDLE to EXEC: on acceptance of a request.
  - EXEC to RESP: unconditionally after one cycle.
  - RESP to IDLE: when rsp_ready is high.
- REQ-017 Grant timing and encoding:
  - req_ready SHALL be nonzero only in IDLE.
  - req_ready SHALL be combinational from req_valid and the priority pointer.
  - req_ready SHALL have at most one bit set.
- REQ-018 Arbitration SHALL be round-robin. The lowest index at or above the pointer wins, wrapping at NREQ. After a grant to requester i, the pointer SHALL become (i+1) mod NREQ.
- REQ-019 On acceptance, the block SHALL capture a, b, sub, cin and the requester index into operand registers; later changes on req_* inputs SHALL NOT affect the captured operation.
- REQ-020 In EXEC, the block SHALL compute the result into the result register:
  - add: {0,a} + {0,b} + cin
  - subtract: {0,a} - {0,b} modulo 2^(W+1); cin ignored.
- REQ-021 Response timing and stability:
  - rsp_valid SHALL assert in RESP, 2 cycles after the acceptance edge.
  - rsp_sum and rsp_id SHALL hold stable while rsp_valid is high and rsp_ready is low.
- REQ-022 At most one operation SHALL be outstanding. Peak throughput is one operation per 3 cycles when rsp_ready is held high.
- REQ-023 If req_valid deasserts after the grant edge, the accepted operation SHALL still complete.
- REQ-024 If no req_valid bit is set in IDLE, the FSM and pointer SHALL hold.

Reset
- REQ-025 While reset is high at a clock edge, the block SHALL:
  - force the FSM to IDLE;
  - set the pointer to 0;
  - clear rsp_valid, rsp_id, rsp_sum and busy;
  - drive req_ready to 0.
- REQ-026 Reset asserted in EXEC or RESP SHALL abort the operation, and no response SHALL be emitted for it.
- REQ-027 In the first cycle after reset release, the block SHALL grant requests normally.

Configuration
- REQ-028 With macro ADDSUB_ARB_LOCK_EN defined:
  - the block SHALL have extra input req_lock, NREQ bits, captured with the operands;
  - if the captured lock is set, the next grant SHALL go to the same requester when its req_valid is high, bypassing rotation and leaving the pointer unchanged;
  - if that requester's req_valid is low in IDLE, the lock SHALL be released and round-robin SHALL apply.
- REQ-029 Without ADDSUB_ARB_LOCK_EN, port req_lock SHALL be absent and arbitration SHALL be pure round-robin.

Structure
- REQ-030 Shared package addsub_pkg SHALL hold:
  - the FSM state enum (IDLE/EXEC/RESP);
  - the op-encoding constants ADD=0, SUB=1.
- REQ-031 The datapath SHALL be the sub-module addsub_core: a registered W-bit add/subtract with enable and synchronous clear, instanced once.
- REQ-032 Arbitration, FSM and response logic SHALL reside in addsub_arb.

Verification
- REQ-033 Add: req0 a=0xFF, b=0x01, sub=0, cin=1, rsp_ready=1 -> rsp_valid 2 cycles after acceptance with rsp_sum=0x101, rsp_id=0.
- REQ-034 Subtract: req2 a=0x05, b=0x07, sub=1, cin=1 -> rsp_sum=0x1FE (cin ignored), rsp_id=2.
- REQ-035 Round-robin: all four req_valid held high with rsp_ready=1 -> grant order 0,1,2,3,0, one grant every 3 cycles.
- REQ-036 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_sum stable, req_ready=0; rsp_ready=1 -> IDLE next cycle.
- REQ-037 Reset in EXEC: accept req1, assert reset in the following cycle -> no rsp_valid, pointer=0, next grant goes to req0 when req0 and req1 are both valid.
- REQ-038 Lock (ADDSUB_ARB_LOCK_EN only): req1 lock=1 with req1 and req2 valid -> req1 granted twice in succession; req1 valid dropped -> req2 granted.
